pe_recv_buffer: RTL and testbench
=================================

# pe_recv_buffer

Receive-side network interface between a CONNECT router output port and a processing element. It accepts flits from the router, stores them in one FIFO per virtual channel, and presents them to the PE one at a time under round-robin VC arbitration. For each flit the PE consumes, it returns one credit to the router. It absorbs every flit the router's credit counters allow and never applies backpressure on the flit path.

## Interface
Parameters:
- NUM_VCS, 2, number of virtual channels (≥1); VC_BITS = (NUM_VCS>1) ? $clog2(NUM_VCS) : 1
- FLIT_DATA_WIDTH, 32, payload bits per flit
- DEST_BITS, 2, destination field width
- BUFFER_DEPTH, 4, entries per VC FIFO (≥2, power of two); must equal the router's initial credit count
- FW (derived) = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH; flit layout MSB→LSB: {valid, tail, dest, vc, data}

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; low blocks dequeue and credit return, never blocks enqueue
- flit_in  in  FW  flit from router; captured when bit FW-1 (valid) = 1
- credit_out  out  1+VC_BITS  {valid, vc} credit to router
- deq_valid  out  1  a buffered flit is presented
- deq_flit  out  FW  presented flit, valid bit forced to 1
- deq_ready  in  1  PE accepts the presented flit
- overflow_err  out  1  sticky; a flit arrived for a full VC
- pkt_count  out  32  tail flits dequeued (only with PE_RECV_STATS_EN)

## Operation
- One FIFO per VC, BUFFER_DEPTH deep. Read and write pointers are $clog2(BUFFER_DEPTH) bits and wrap modulo depth. Occupancy is $clog2(BUFFER_DEPTH+1) bits.
- Enqueue: a valid flit_in is written to FIFO[flit_in.vc] at the rising edge. A vc field ≥ NUM_VCS is dropped and sets overflow_err.
- Arbitration: round-robin pointer rr (VC_BITS).
  - The selected VC is the first non-empty VC searching rr, rr+1, … modulo NUM_VCS.
  - deq_valid = en & (any VC non-empty). deq_flit = head of the selected VC.
- Dequeue occurs at an edge where deq_valid & deq_ready. Then:
  - the selected FIFO's read pointer advances;
  - rr becomes selected+1 modulo NUM_VCS;
  - a credit for that VC is registered.
- Credit: credit_out = {1, vc} for exactly one cycle following each dequeue; otherwise 0. Maximum one credit per cycle.
- Full VC plus simultaneous enqueue and dequeue on that VC: occupancy is evaluated after the dequeue, so the write succeeds and occupancy stays at BUFFER_DEPTH.
- Full VC with enqueue and no dequeue: the flit is dropped, overflow_err is set to 1 until reset, and FIFO contents are unchanged.
- Empty VC: a flit enqueued at edge N is first presentable in cycle N+1. There is no bypass.
- en low: deq_valid = 0, no dequeue, no credit issued, rr held. Enqueue continues.
- Reset, including mid-operation: all FIFOs empty, rr = 0, credit_out = 0, deq_valid = 0, deq_flit = 0, overflow_err = 0, pkt_count = 0. In-flight flits are discarded and no credits are returned for them.

## Timing
- Enqueue-to-presentation latency is 1 cycle. deq_valid/deq_flit are combinational from registered state and en.
- Dequeue-to-credit latency is 1 cycle (credit_out is a registered output).
- Round-trip minimum: a flit arriving at edge N into an empty buffer, with deq_ready high, has its credit on credit_out during cycle N+2.
- Sustained throughput is 1 flit/cycle across any VC mix.

## Configuration
- PE_RECV_STATS_EN defined: the pkt_count port exists. It increments by 1 on each dequeue whose tail bit is 1 and wraps at 2^32.
- PE_RECV_STATS_EN undefined: the pkt_count port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then a single flit with vc=0 and data=0xA5 at edge 1 → deq_valid=1 in cycle 2 with deq_flit data=0xA5. With deq_ready=1, credit_out={1,0} in cycle 3 only.
- Fill VC1 with 4 flits while deq_ready=0, then a 5th flit to VC1 → overflow_err=1 and stays 1. Draining with deq_ready=1 yields exactly the first 4 flits and returns 4 credits with vc=1.
- VC0 and VC1 each hold 3 flits, deq_ready held at 1 → dequeue order alternates VC0, VC1, VC0, VC1, VC0, VC1, one per cycle. Credits follow the same VC order, each 1 cycle later.
- VC0 full, with enqueue to VC0 and dequeue from VC0 at the same edge → no overflow_err, occupancy remains 4, FIFO order preserved.
- en=0 while 2 flits arrive → deq_valid=0 and credit_out=0 throughout. After en=1, both flits are presented in order.
- With PE_RECV_STATS_EN: dequeue a 3-flit packet (tail on the 3rd flit) twice → pkt_count=2. Assert rst_n low mid-packet → pkt_count=0, deq_valid=0, buffers empty.

Source files
------------

// File: rtl/pe_recv_buffer_if.sv
// pe_recv_buffer_if
//   Bundles the flit and credit path between a CONNECT router output port
//   and the PE, along with the dequeue handshake toward the PE.
//   Signals:
//     flit_in    router -> buffer  {valid, tail, dest, vc, data}
//     credit_out buffer -> router  {valid, vc}, one pulse per consumed flit
//     deq_valid  buffer -> PE      a buffered flit is presented
//     deq_flit   buffer -> PE      presented flit (valid bit forced high)
//     deq_ready  PE -> buffer      PE accepts the presented flit
//   Modports: slave = the receive buffer, master = the environment
//   (router + PE side).
interface pe_recv_buffer_if #(
  parameter int NUM_VCS         = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2
);
  localparam int VC_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int FW      = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

  logic [FW-1:0]    flit_in;
  logic [VC_BITS:0] credit_out;
  logic             deq_valid;
  logic [FW-1:0]    deq_flit;
  logic             deq_ready;

  modport master (
    output flit_in,
    output deq_ready,
    input  credit_out,
    input  deq_valid,
    input  deq_flit
  );

  modport slave (
    input  flit_in,
    input  deq_ready,
    output credit_out,
    output deq_valid,
    output deq_flit
  );
endinterface

// File: rtl/pe_recv_buffer.sv
// pe_recv_buffer
//   Receive-side network interface: flits from the router are stored in one
//   FIFO per virtual channel and presented to the PE one at a time under
//   round-robin VC arbitration. Every consumed flit returns one credit to
//   the router on the following cycle. The flit path is never backpressured;
//   a flit that finds its VC full (or names a nonexistent VC) is dropped and
//   raises a sticky overflow flag.
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     en           low blocks dequeue/credit return; enqueue always proceeds
//     bus          pe_recv_buffer_if.slave (flit_in, credit_out, deq_*)
//     overflow_err sticky flag, flit arrived for a full or invalid VC
//     pkt_count    tail flits dequeued (present only with PE_RECV_STATS_EN)
//   Configuration macro: PE_RECV_STATS_EN enables the pkt_count port/counter.
module pe_recv_buffer #(
  parameter int NUM_VCS         = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int BUFFER_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  pe_recv_buffer_if.slave bus,
  output logic            overflow_err
`ifdef PE_RECV_STATS_EN
  ,
  output logic [31:0]     pkt_count
`endif
);

  localparam int VC_BITS  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int FW       = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
  // Stored entries drop the valid bit; it is implied by occupancy.
  localparam int PW       = FW - 1;
  localparam int PTR_BITS = $clog2(BUFFER_DEPTH);
  localparam int CNT_BITS = $clog2(BUFFER_DEPTH + 1);
  localparam int VC_LSB   = FLIT_DATA_WIDTH;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(BUFFER_DEPTH);

  logic [PW-1:0]       mem_r    [NUM_VCS][BUFFER_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_r [NUM_VCS];
  logic [PTR_BITS-1:0] rd_ptr_r [NUM_VCS];
  logic [CNT_BITS-1:0] count_r  [NUM_VCS];
  logic [VC_BITS-1:0]  rr_r;
  logic [VC_BITS:0]    credit_r;
  logic                overflow_r;

  logic                in_valid_s;
  logic [VC_BITS-1:0]  in_vc_s;
  logic                vc_ok_s;
  logic [NUM_VCS-1:0]  nonempty_s;
  logic [NUM_VCS-1:0]  full_s;
  logic [NUM_VCS-1:0]  enq_req_s;
  logic [NUM_VCS-1:0]  enq_ok_s;
  logic [NUM_VCS-1:0]  deq_oh_s;
  logic                found_s;
  logic [VC_BITS-1:0]  sel_vc_s;
  logic [VC_BITS-1:0]  rr_nxt_s;
  logic                deq_valid_s;
  logic                deq_fire_s;
  logic [PW-1:0]       head_s;
  logic                drop_s;

  // Decode the header of the incoming flit.
  always_comb begin
    in_valid_s = bus.flit_in[FW-1];
    in_vc_s    = bus.flit_in[VC_LSB +: VC_BITS];
    // Widen before comparing so non-power-of-two VC counts are caught.
    vc_ok_s    = (32'(in_vc_s) < 32'(NUM_VCS));
  end

  // Per-VC empty/full status from the occupancy counters.
  always_comb begin
    nonempty_s = {NUM_VCS{1'b0}};
    full_s     = {NUM_VCS{1'b0}};
    for (int v = 0; v < NUM_VCS; v++) begin
      nonempty_s[v] = (count_r[v] != {CNT_BITS{1'b0}});
      full_s[v]     = (count_r[v] == FULL_CNT);
    end
  end

  // Round-robin search: first non-empty VC starting at rr_r.
  always_comb begin
    int idx;
    idx      = 0;
    found_s  = 1'b0;
    sel_vc_s = {VC_BITS{1'b0}};
    for (int k = 0; k < NUM_VCS; k++) begin
      idx = (int'(rr_r) + k) % NUM_VCS;
      if (!found_s && nonempty_s[idx]) begin
        found_s  = 1'b1;
        sel_vc_s = VC_BITS'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Presentation, dequeue decision and next arbiter pointer.
  always_comb begin
    deq_valid_s = en & found_s;
    deq_fire_s  = deq_valid_s & bus.deq_ready;
    head_s      = mem_r[sel_vc_s][rd_ptr_r[sel_vc_s]];
    deq_oh_s    = {NUM_VCS{1'b0}};
    for (int v = 0; v < NUM_VCS; v++) begin
      deq_oh_s[v] = deq_fire_s && (sel_vc_s == VC_BITS'(v));
    end
    if (sel_vc_s == VC_BITS'(NUM_VCS - 1)) begin
      rr_nxt_s = {VC_BITS{1'b0}};
    end else begin
      rr_nxt_s = sel_vc_s + VC_BITS'(1);
    end
  end

  // Enqueue acceptance; a full VC still accepts when it is dequeued at the
  // same edge, because occupancy is judged after the dequeue.
  always_comb begin
    enq_req_s = {NUM_VCS{1'b0}};
    enq_ok_s  = {NUM_VCS{1'b0}};
    for (int v = 0; v < NUM_VCS; v++) begin
      enq_req_s[v] = in_valid_s && vc_ok_s && (in_vc_s == VC_BITS'(v));
      enq_ok_s[v]  = enq_req_s[v] && (!full_s[v] || deq_oh_s[v]);
    end
    drop_s = (in_valid_s & ~vc_ok_s) | (|(enq_req_s & ~enq_ok_s));
  end

  assign bus.deq_valid  = deq_valid_s;
  assign bus.deq_flit   = deq_valid_s ? {1'b1, head_s} : {FW{1'b0}};
  assign bus.credit_out = credit_r;
  assign overflow_err   = overflow_r;

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (enq_ok_s[v]) begin
        mem_r[v][wr_ptr_r[v]] <= bus.flit_in[PW-1:0];
      end
    end
  end

  // Per-VC read/write pointers and occupancy counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_r[v] <= {PTR_BITS{1'b0}};
        rd_ptr_r[v] <= {PTR_BITS{1'b0}};
        count_r[v]  <= {CNT_BITS{1'b0}};
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (enq_ok_s[v]) begin
          wr_ptr_r[v] <= wr_ptr_r[v] + PTR_BITS'(1);
        end
        if (deq_oh_s[v]) begin
          rd_ptr_r[v] <= rd_ptr_r[v] + PTR_BITS'(1);
        end
        case ({enq_ok_s[v], deq_oh_s[v]})
          2'b10:   count_r[v] <= count_r[v] + CNT_BITS'(1);
          2'b01:   count_r[v] <= count_r[v] - CNT_BITS'(1);
          default: count_r[v] <= count_r[v];
        endcase
      end
    end
  end

  // Arbiter pointer, one-cycle credit pulse and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r       <= {VC_BITS{1'b0}};
      credit_r   <= {(VC_BITS + 1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (deq_fire_s) begin
        rr_r <= rr_nxt_s;
      end
      credit_r <= deq_fire_s ? {1'b1, sel_vc_s} : {(VC_BITS + 1){1'b0}};
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef PE_RECV_STATS_EN
  logic [31:0] pkt_count_r;

  // Count dequeued tail flits; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_r <= 32'd0;
    end else if (deq_fire_s && head_s[PW-1]) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end
  end

  assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_pe_recv_buffer.sv
// tb_pe_recv_buffer
//   Self-checking bench for pe_recv_buffer. A queue-per-VC reference model
//   predicts deq_valid, deq_flit, credit_out, overflow_err (and pkt_count
//   when PE_RECV_STATS_EN is defined) every cycle; directed phases follow
//   the intended usage scenarios and a randomized phase follows.
module tb_pe_recv_buffer;
  localparam int NUM_VCS         = 2;
  localparam int FLIT_DATA_WIDTH = 32;
  localparam int DEST_BITS       = 2;
  localparam int BUFFER_DEPTH    = 4;
  localparam int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int FW              = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic ovf;
`ifdef PE_RECV_STATS_EN
  logic [31:0] pkt_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [FW-1:0]    q [NUM_VCS][$];
  int               m_rr;
  logic [VC_BITS:0] m_credit;
  logic             m_ovf;
  logic [31:0]      m_pkt;

  pe_recv_buffer_if #(
    .NUM_VCS(NUM_VCS), .FLIT_DATA_WIDTH(FLIT_DATA_WIDTH), .DEST_BITS(DEST_BITS)
  ) bus ();

  pe_recv_buffer #(
    .NUM_VCS(NUM_VCS), .FLIT_DATA_WIDTH(FLIT_DATA_WIDTH),
    .DEST_BITS(DEST_BITS), .BUFFER_DEPTH(BUFFER_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .bus(bus),
    .overflow_err(ovf)
`ifdef PE_RECV_STATS_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int vc, input logic [31:0] data,
                                       input logic tail, input logic [DEST_BITS-1:0] dest);
    logic [VC_BITS-1:0] v;
    v = VC_BITS'(vc);
    return {1'b1, tail, dest, v, data};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_VCS; i++) q[i].delete();
    m_rr     = 0;
    m_credit = '0;
    m_ovf    = 1'b0;
    m_pkt    = 32'd0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model by the rules applied at the rising edge.
  task automatic cycle(input logic [FW-1:0] f, input logic rdy, input logic e);
    int            sel;
    int            c;
    int            v;
    logic          dv;
    logic [FW-1:0] exp_f;
    logic [FW-1:0] h;
    bus.flit_in   = f;
    bus.deq_ready = rdy;
    en            = e;
    @(negedge clk);
    sel = -1;
    for (int k = 0; k < NUM_VCS; k++) begin
      c = (m_rr + k) % NUM_VCS;
      if (sel < 0 && q[c].size() > 0) sel = c;
    end
    dv    = e && (sel >= 0);
    exp_f = '0;
    if (dv) exp_f = q[sel][0];
    check("deq_valid", 64'(bus.deq_valid), 64'(dv));
    check("deq_flit", 64'(bus.deq_flit), 64'(exp_f));
    check("credit_out", 64'(bus.credit_out), 64'(m_credit));
    check("overflow_err", 64'(ovf), 64'(m_ovf));
`ifdef PE_RECV_STATS_EN
    check("pkt_count", 64'(pkt_count), 64'(m_pkt));
`endif
    @(posedge clk);
    if (dv && rdy) begin
      h = q[sel].pop_front();
      if (h[FW-2]) m_pkt = m_pkt + 32'd1;
      m_credit = {1'b1, sel[VC_BITS-1:0]};
      m_rr     = (sel + 1) % NUM_VCS;
    end else begin
      m_credit = '0;
    end
    if (f[FW-1]) begin
      v = int'(f[FLIT_DATA_WIDTH +: VC_BITS]);
      if (v < NUM_VCS && q[v].size() < BUFFER_DEPTH) q[v].push_back(f);
      else m_ovf = 1'b1;
    end
    #1;
  endtask

  // Assert reset away from the clock edge, check the reset state, release.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_deq_flit", 64'(bus.deq_flit), 64'd0);
    check("rst_credit", 64'(bus.credit_out), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
`ifdef PE_RECV_STATS_EN
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    bus.flit_in   = '0;
    bus.deq_ready = 1'b0;
    en            = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [FW-1:0] idle;
    logic [FW-1:0] f;
    idle          = '0;
    bus.flit_in   = '0;
    bus.deq_ready = 1'b0;
    model_clear();
    do_reset();
    cycle(idle, 1'b0, 1'b1);

    // Single flit latency and credit round trip.
    cycle(mk(0, 32'hA5, 1'b0, 2'd0), 1'b1, 1'b1);
    cycle(idle, 1'b1, 1'b1);
    cycle(idle, 1'b1, 1'b1);
    cycle(idle, 1'b1, 1'b1);

    // Fill VC1, overflow on the fifth flit, then drain.
    for (int i = 0; i < 5; i++) cycle(mk(1, 32'h100 + i, 1'b0, 2'd1), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(idle, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(idle, 1'b1, 1'b1);
    check("overflow_sticky", 64'(ovf), 64'd1);
    do_reset();

    // Alternating round-robin across two loaded VCs.
    for (int i = 0; i < 3; i++) begin
      cycle(mk(0, 32'h200 + i, 1'b0, 2'd2), 1'b0, 1'b1);
      cycle(mk(1, 32'h300 + i, 1'b0, 2'd3), 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) cycle(idle, 1'b1, 1'b1);

    // Full VC0 with simultaneous enqueue and dequeue.
    for (int i = 0; i < 4; i++) cycle(mk(0, 32'h400 + i, 1'b0, 2'd0), 1'b0, 1'b1);
    cycle(mk(0, 32'h4FF, 1'b0, 2'd0), 1'b1, 1'b1);
    cycle(idle, 1'b0, 1'b1);
    check("no_overflow_on_swap", 64'(ovf), 64'd0);
    for (int i = 0; i < 6; i++) cycle(idle, 1'b1, 1'b1);

    // Enable low: arrivals buffered, nothing presented or credited.
    cycle(mk(1, 32'h500, 1'b0, 2'd1), 1'b1, 1'b0);
    cycle(mk(1, 32'h501, 1'b1, 2'd1), 1'b1, 1'b0);
    cycle(idle, 1'b1, 1'b0);
    cycle(idle, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(idle, 1'b1, 1'b1);

    // Packets: two 3-flit packets, then a reset in the middle of a third.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) cycle(mk(0, 32'h600 + i, i == 2, 2'd0), 1'b1, 1'b1);
    end
    cycle(idle, 1'b1, 1'b1);
    cycle(idle, 1'b1, 1'b1);
`ifdef PE_RECV_STATS_EN
    check("pkt_count_two", 64'(pkt_count), 64'd2);
`endif
    cycle(mk(1, 32'h700, 1'b0, 2'd0), 1'b0, 1'b1);
    cycle(mk(1, 32'h701, 1'b0, 2'd0), 1'b0, 1'b1);
    do_reset();
    cycle(idle, 1'b1, 1'b1);
    cycle(idle, 1'b1, 1'b1);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      f = '0;
      if ($urandom_range(0, 9) < 6) begin
        f = mk(int'($urandom_range(0, NUM_VCS - 1)), $urandom,
               ($urandom_range(0, 1) == 1), DEST_BITS'($urandom_range(0, 3)));
      end
      cycle(f, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) != 0));
      if (i == 200) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
